// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types for the RV32I memory arbiter.
// FSM state, requester owner and memory command/response bundles.
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } mem_rsp_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/rv32i_arb_pick.sv
// rv32i_arb_pick: two-way request picker for the memory arbiter.
// RV32I_ARB_ROUND_ROBIN_EN: alternate on ties, else data wins.
module rv32i_arb_pick
  import rv32i_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
`ifdef RV32I_ARB_ROUND_ROBIN_EN
  input  owner_t last_owner,
`endif
  output logic   pick_valid,
  output owner_t pick_owner
);

  always_comb begin
    pick_valid = if_req | d_req;
    pick_owner = OWN_IF;
    unique case (1'b1)
`ifdef RV32I_ARB_ROUND_ROBIN_EN
      (if_req & d_req):  pick_owner = other_owner(last_owner);
      (d_req & ~if_req): pick_owner = OWN_D;
`else
      d_req:             pick_owner = OWN_D;
`endif
      default:           pick_owner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: fetch/data arbiter onto one memory port.
// RV32I_ARB_ROUND_ROBIN_EN selects round-robin over data-first.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic            if_err,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic            d_err,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  arb_state_t state;
  owner_t     owner;
  logic [7:0] wait_cnt;
  mem_cmd_t   cmd;
  mem_rsp_t   rsp;
  logic       pick_valid;
  owner_t     pick_owner;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
  owner_t     last_owner;
`endif

  rv32i_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef RV32I_ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wait_cnt  <= '0;
      cmd       <= '0;
      rsp       <= '0;
      mem_req   <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
      last_owner <= OWN_IF;
`endif
    end else begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_owner;
            wait_cnt <= '0;
            mem_req  <= 1'b1;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
            last_owner <= pick_owner;
`endif
            if (pick_owner == OWN_D) begin
              state <= BUSY_D;
              d_gnt <= 1'b1;
              cmd   <= '{we: d_we, addr: d_addr, wdata: d_wdata};
            end else begin
              state  <= BUSY_IF;
              if_gnt <= 1'b1;
              cmd    <= '{we: 1'b0, addr: if_addr, wdata: '0};
            end
          end
        end
        BUSY_IF, BUSY_D: begin
          // ready wins over a timeout landing in the same cycle
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            cmd     <= '0;
            rsp     <= '{err: 1'b0, data: cmd.we ? '0 : mem_rdata};
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= RESP;
            mem_req <= 1'b0;
            cmd     <= '0;
            rsp     <= '{err: 1'b1, data: '0};
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (owner == OWN_D) begin
            d_rvalid <= 1'b1;
            d_err    <= rsp.err;
            d_rdata  <= rsp.data;
          end else begin
            if_rvalid <= 1'b1;
            if_err    <= rsp.err;
            if_rdata  <= rsp.data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed and randomized checks of the arbiter
// against a transaction timeline model of grant/complete/respond.
module tb_rv32i_mem_arbiter;
  import rv32i_pkg::*;

  localparam int TMO = 16;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  rv32i_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_err    (if_err),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_err     (d_err),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  obs_t dut_o, exp_o;
  assign dut_o = {if_gnt, if_rvalid, if_err, if_rdata,
                  d_gnt, d_rvalid, d_err, d_rdata,
                  mem_req, mem_we, mem_addr, mem_wdata};

  int n_tests = 0;
  int n_fail = 0;
  bit model_ok = 1'b0;

  // timeline model state
  int          cyc = 0;
  bit          m_busy = 1'b0;
  owner_t      m_own = OWN_IF;
  int          m_start = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          rv_at = -1;
  owner_t      rv_own = OWN_IF;
  logic [31:0] rv_data = '0;
  bit          rv_err = 1'b0;
  int          free_cyc = 0;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
  owner_t      m_last = OWN_IF;
`endif

  task automatic check(input string nm, input logic [135:0] act,
                       input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // predicts outputs of cycle cyc+1 from inputs seen in cycle cyc
  task automatic model_step();
    obs_t   e;
    bit     terr;
    owner_t w;
    e = '0;
    if (reset) begin
      m_busy   = 1'b0;
      rv_at    = -1;
      free_cyc = cyc + 1;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
      m_last   = OWN_IF;
`endif
    end else begin
      if (m_busy) begin
        terr = !mem_ready && (cyc - m_start + 1 >= TMO);
        if (mem_ready || terr) begin
          m_busy   = 1'b0;
          rv_at    = cyc + 2;
          rv_own   = m_own;
          rv_err   = terr;
          rv_data  = (terr || m_we) ? 32'h0 : mem_rdata;
          free_cyc = cyc + 2;
        end else begin
          e.mem_req   = 1'b1;
          e.mem_we    = m_we;
          e.mem_addr  = m_addr;
          e.mem_wdata = m_wdata;
        end
      end else if (cyc >= free_cyc && (if_req || d_req)) begin
`ifdef RV32I_ARB_ROUND_ROBIN_EN
        if (if_req && d_req)
          w = (m_last == OWN_IF) ? OWN_D : OWN_IF;
        else
          w = d_req ? OWN_D : OWN_IF;
        m_last = w;
`else
        w = d_req ? OWN_D : OWN_IF;
`endif
        m_busy  = 1'b1;
        m_own   = w;
        m_start = cyc + 1;
        if (w == OWN_D) begin
          e.d_gnt = 1'b1;
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
        end else begin
          e.if_gnt = 1'b1;
          m_we     = 1'b0;
          m_addr   = if_addr;
          m_wdata  = 32'h0;
        end
        e.mem_req   = 1'b1;
        e.mem_we    = m_we;
        e.mem_addr  = m_addr;
        e.mem_wdata = m_wdata;
      end
      if (rv_at == cyc + 1) begin
        if (rv_own == OWN_D) begin
          e.d_rvalid = 1'b1;
          e.d_err    = rv_err;
          e.d_rdata  = rv_data;
        end else begin
          e.if_rvalid = 1'b1;
          e.if_err    = rv_err;
          e.if_rdata  = rv_data;
        end
        rv_at = -1;
      end
    end
    exp_o = e;
    cyc++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        n_tests++;
        if (dut_o !== exp_o) begin
          n_fail++;
          $display("FAIL model_cmp cyc=%0d got=%0h want=%0h",
                   cyc, dut_o, exp_o);
        end
      end
      model_step();
      model_ok = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_state", dut_o, '0);
  endtask

  int          n;
  int          g;
  int          pct;
  logic [1:0]  ord;
  logic [1:0]  exp_ord;
  int          pct_tab [4] = '{3, 25, 60, 95};

  initial begin
    step();
    do_reset();

    // fetch read, ready on the first busy cycle
    if_req  = 1'b1;
    if_addr = 32'h100;
    step();
    check("t028_gnt", {if_gnt, d_gnt, mem_req, mem_we}, 4'b1010);
    check("t028_addr", mem_addr, 32'h100);
    if_req    = 1'b0;
    if_addr   = $urandom;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0013;
    step();
    check("t028_resp", {mem_req, if_rvalid}, 2'b00);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    step();
    check("t028_rvalid", {if_rvalid, if_err, d_rvalid}, 3'b100);
    check("t028_rdata", if_rdata, 32'h0000_0013);
    step();
    check("t028_pulse", if_rvalid, 1'b0);

    // data write with four wait cycles
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_addr    = 32'h2000;
    d_wdata   = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    step();
    check("t029_gnt", {d_gnt, if_gnt}, 2'b10);
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = $urandom;
    d_wdata = $urandom;
    n = 0;
    for (int k = 1; k <= 5; k++) begin
      if (mem_req && mem_we && mem_addr == 32'h2000 &&
          mem_wdata == 32'hDEAD_BEEF)
        n++;
      mem_ready = (k == 5);
      step();
    end
    check("t029_held", n, 5);
    check("t029_drop", mem_req, 1'b0);
    mem_ready = 1'b0;
    step();
    check("t029_rvalid", {d_rvalid, d_err}, 2'b10);
    check("t029_rdata", d_rdata, 32'h0);

    // simultaneous requests, twice
    do_reset();
    mem_ready = 1'b1;
    if_req    = 1'b1;
    if_addr   = 32'h400;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h800;
    g   = 0;
    ord = '0;
    for (int k = 0; k < 40 && g < 2; k++) begin
      step();
      if (if_gnt || d_gnt) begin
        ord[1-g] = d_gnt;
        g++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
`ifdef RV32I_ARB_ROUND_ROBIN_EN
    exp_ord = 2'b10;
`else
    exp_ord = 2'b11;
`endif
    check("t030_count", g, 2);
    check("t030_order", ord, exp_ord);
    repeat (6) step();
    mem_ready = 1'b0;

    // data read timeout
    do_reset();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h40;
    mem_rdata = 32'hA5A5_A5A5;
    step();
    check("t031_gnt", d_gnt, 1'b1);
    d_req = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("t031_busy", n, TMO);
    check("t031_resp", d_rvalid, 1'b0);
    step();
    check("t031_err", {d_rvalid, d_err}, 2'b11);
    check("t031_rdata", d_rdata, 32'h0);

    // reset during a fetch
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h300;
    step();
    check("t032_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    reset  = 1'b1;
    step();
    check("t032_abort", mem_req, 1'b0);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (if_rvalid) n++;
    end
    check("t032_norv", n, 0);
    d_req  = 1'b1;
    d_addr = 32'h8;
    step();
    check("t032_idle", d_gnt, 1'b1);
    d_req     = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();
    mem_ready = 1'b0;

    // stray ready while idle
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (dut_o != '0) n++;
    end
    check("t033_quiet", n, 0);
    mem_ready = 1'b0;

    // randomized traffic
    do_reset();
    pct = 25;
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) pct = pct_tab[$urandom_range(0, 3)];
      reset = ($urandom_range(0, 299) == 0);
      if (if_req && if_gnt) begin
        if_req  = 1'b0;
        if_addr = $urandom;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (d_req && d_gnt) begin
        d_req   = 1'b0;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 99) < pct);
      mem_rdata = $urandom;
      step();
    end
    reset     = 1'b0;
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles waiting on mem_ready before abort (range 1..255).
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req / if_addr  in  1 / 32  fetch requester: read request and byte address.
REQ-005 if_gnt / if_rvalid / if_err / if_rdata  out  1/1/1/32  fetch: grant pulse, completion pulse, timeout flag, read data.
REQ-006 d_req / d_we / d_addr / d_wdata  in  1/1/32/32  data requester: request, write enable, address, write data.
REQ-007 d_gnt / d_rvalid / d_err / d_rdata  out  1/1/1/32  data: grant pulse, completion pulse, timeout flag, read data.
REQ-008 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/32/32  shared memory port request.
REQ-009 mem_ready / mem_rdata  in  1/32  memory accept-and-complete strobe, read data valid with mem_ready.

Function
REQ-010 FSM states SHALL be IDLE, BUSY_IF, BUSY_D, RESP; all outputs registered.
REQ-011 IDLE, only if_req=1 (cycle N): next cycle if_gnt=1 for one cycle, state BUSY_IF, mem_req=1, mem_we=0, mem_addr=latched if_addr.
REQ-012 IDLE, only d_req=1 (cycle N): next cycle d_gnt=1 for one cycle, state BUSY_D, mem_req=1, mem_we/mem_addr/mem_wdata=latched d_we/d_addr/d_wdata.
REQ-013 Requesters hold req and payload until their gnt; payload after gnt is ignored.
REQ-014 BUSY_x: mem_req and payload SHALL stay stable until and including the cycle mem_ready=1; next cycle mem_req=0, state RESP.
REQ-015 RESP: owner rvalid=1 for exactly one cycle, rdata=mem_rdata captured at mem_ready (0 for writes), err=0; then IDLE.
REQ-016 Minimum turnaround: req seen in IDLE to rvalid = 3 cycles when mem_ready arrives the first BUSY cycle; next grant no earlier than the cycle after RESP.
REQ-017 8-bit wait counter cleared on grant, incremented each BUSY cycle without mem_ready; reaching TIMEOUT SHALL drop mem_req, enter RESP with err=1, rdata=0.
REQ-018 mem_ready while IDLE or RESP SHALL be ignored.
REQ-019 Simultaneous if_req and d_req in IDLE: arbitration per REQ-024/025; loser stays pending and is granted at the next IDLE.
REQ-020 gnt, rvalid, err SHALL never be high for both requesters in the same cycle; at most one outstanding memory transaction.

Reset
REQ-021 reset=1 SHALL force IDLE, wait counter 0, last-owner = fetch, all outputs 0 on the next edge.
REQ-022 Reset mid-transaction SHALL abandon it: mem_req=0 next cycle, no rvalid issued.

Configuration
REQ-023 Macro RV32I_ARB_ROUND_ROBIN_EN selects arbitration policy.
REQ-024 Defined: simultaneous requests granted to the requester not granted last (last-owner register updated on every grant).
REQ-025 Undefined: fixed priority, data always wins; last-owner register not implemented.

Structure
REQ-026 Shared package rv32i_pkg SHALL hold FSM state enum, owner encoding (OWN_IF=0, OWN_D=1) and the 32-bit address/data width constant.
REQ-027 Sub-module rv32i_arb_pick (combinational two-way picker, policy per macro) SHALL be instantiated once; everything else in rv32i_mem_arbiter.

Verification
REQ-028 if_req, if_addr=0x100, mem_ready next cycle with mem_rdata=0x00000013 -> if_gnt pulse, mem_addr=0x100, if_rvalid with if_rdata=0x00000013, 3 cycles after req.
REQ-029 d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_ready after 4 wait cycles -> mem_req held 5 cycles with stable payload, d_rvalid=1, d_rdata=0.
REQ-030 Both req together twice back-to-back -> with macro grants D then IF; without macro D then D.
REQ-031 d_req read, mem_ready never asserted, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, d_rvalid=1, d_err=1, d_rdata=0.
REQ-032 reset asserted during BUSY_IF -> next cycle mem_req=0, if_rvalid never pulses, FSM IDLE.
REQ-033 mem_ready=1 while IDLE with no requests -> no rvalid, no gnt, outputs stay 0.
